// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg -- shared types and defaults for the shared-multiplier arbiter.
//   W_DEF / MUL_LAT_DEF : default operand width and multiplier latency
//   PROD_W              : product width for the default operand width (2*W)
//   req_id_t            : requester index (0 or 1)
//   tag_t               : per-issue tag {valid, id} carried alongside the multiplier
package mul_arb_pkg;

  localparam int W_DEF       = 24;
  localparam int MUL_LAT_DEF = 3;
  localparam int PROD_W      = 2 * W_DEF;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/mul_arb_rr2.sv
// mul_arb_rr2 -- two-way round-robin grant with its priority pointer.
//   clk, rstN : clock, asynchronous active-low reset
//   flush     : synchronous flush; blocks grants and returns priority to requester 0
//   reqValid  : per-requester request
//   grant     : one-hot (or zero) grant, combinational from reqValid and the pointer
module mul_arb_rr2
  import mul_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rstN,
  input  logic       flush,
  input  logic [1:0] reqValid,
  output logic [1:0] grant
);

  req_id_t ptr_r;

  // Grant selection: a lone requester always wins, contention resolved by the pointer.
  always_comb begin
    grant = 2'b00;
    if (flush) begin
      grant = 2'b00;
    end else begin
      case (reqValid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_r ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Priority pointer: after serving requester i, favour the other one next.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr_r <= 1'b0;
    end else if (flush) begin
      ptr_r <= 1'b0;
    end else if (grant != 2'b00) begin
      ptr_r <= ~grant[1];
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter -- lets two requesters share one fixed-latency multiplier.
//   Clk, RstN            : clock, asynchronous active-low reset
//   Flush                : synchronous flush of all in-flight operations
//   ReqValid / ReqReady  : per-requester handshake (ReqReady is combinational)
//   ReqA0/ReqB0, ReqA1/ReqB1 : operand pairs of requesters 0 and 1
//   MulValid, MulA, MulB : registered issue to the shared multiplier
//   MulProduct           : multiplier result, MUL_LAT cycles after MulValid
//   RspValid, RspProduct : one-cycle response to the owner of MulProduct
//   GrantCnt0/1          : saturating per-requester grant counters when
//                          MUL_ARB_PERF_CNT_EN is defined, constant 0 otherwise
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic [0:0]     Clk,
  input  logic [0:0]     RstN,
  input  logic [0:0]     Flush,
  input  logic [1:0]     ReqValid,
  output logic [1:0]     ReqReady,
  input  logic [W-1:0]   ReqA0,
  input  logic [W-1:0]   ReqB0,
  input  logic [W-1:0]   ReqA1,
  input  logic [W-1:0]   ReqB1,
  output logic [0:0]     MulValid,
  output logic [W-1:0]   MulA,
  output logic [W-1:0]   MulB,
  input  logic [2*W-1:0] MulProduct,
  output logic [1:0]     RspValid,
  output logic [2*W-1:0] RspProduct,
  output logic [15:0]    GrantCnt0,
  output logic [15:0]    GrantCnt1
);

  logic [1:0] grant_s;
  logic       xfer_s;
  req_id_t    xferId_s;
  tag_t       tagPipe_r [MUL_LAT];
  tag_t       tagOut_s;
  logic [1:0] rspValid_r;

  mul_arb_rr2 uRr2 (
    .clk      (Clk),
    .rstN     (RstN),
    .flush    (Flush),
    .reqValid (ReqValid),
    .grant    (grant_s)
  );

  assign ReqReady = grant_s;
  assign xfer_s   = (grant_s != 2'b00);
  assign xferId_s = grant_s[1];
  assign tagOut_s = tagPipe_r[MUL_LAT-1];

  // Issue register: capture the winner's operands; operands hold when idle.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      MulValid <= 1'b0;
      MulA     <= '0;
      MulB     <= '0;
    end else if (Flush) begin
      MulValid <= 1'b0;
    end else begin
      MulValid <= xfer_s;
      if (xfer_s) begin
        MulA <= xferId_s ? ReqA1 : ReqA0;
        MulB <= xferId_s ? ReqB1 : ReqB0;
      end
    end
  end

  // Tag pipeline: tracks which requester owns each product in flight.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      for (int i = 0; i < MUL_LAT; i++) tagPipe_r[i] <= '0;
    end else if (Flush) begin
      for (int i = 0; i < MUL_LAT; i++) tagPipe_r[i] <= '0;
    end else begin
      tagPipe_r[0] <= '{valid: xfer_s, id: xferId_s};
      for (int i = 1; i < MUL_LAT; i++) tagPipe_r[i] <= tagPipe_r[i-1];
    end
  end

  // Response strobe: decode the oldest tag into a one-hot pulse aligned with MulProduct.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      rspValid_r <= 2'b00;
    end else if (Flush) begin
      rspValid_r <= 2'b00;
    end else begin
      rspValid_r <= tagOut_s.valid ? (tagOut_s.id ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  // A pulse already registered for the flush cycle itself belongs to a discarded
  // operation, so it is masked by Flush rather than waiting for the next edge.
  assign RspValid   = rspValid_r & {2{~Flush}};
  assign RspProduct = MulProduct;

`ifdef MUL_ARB_PERF_CNT_EN
  logic [15:0] grantCnt0_r;
  logic [15:0] grantCnt1_r;

  // Grant counters: saturate at all-ones, cleared only by reset.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      grantCnt0_r <= 16'h0000;
      grantCnt1_r <= 16'h0000;
    end else begin
      if (grant_s[0] && (grantCnt0_r != 16'hFFFF)) grantCnt0_r <= grantCnt0_r + 16'h0001;
      if (grant_s[1] && (grantCnt1_r != 16'hFFFF)) grantCnt1_r <= grantCnt1_r + 16'h0001;
    end
  end

  assign GrantCnt0 = grantCnt0_r;
  assign GrantCnt1 = grantCnt1_r;
`else
  assign GrantCnt0 = 16'h0000;
  assign GrantCnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter -- self-checking bench for mul_share_arbiter.
// A queue-based reference model (grant rule, response due times, flush/reset
// discard, saturating counts) is compared against the DUT on every negedge,
// plus literal expectations for the directed scenarios.
module tb_mul_share_arbiter;

  localparam int LAT = 3;
`ifdef MUL_ARB_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        Clk;
  logic        RstN;
  logic        Flush;
  logic [1:0]  ReqValid;
  logic [1:0]  ReqReady;
  logic [23:0] ReqA0, ReqB0, ReqA1, ReqB1;
  logic        MulValid;
  logic [23:0] MulA, MulB;
  logic [47:0] MulProduct;
  logic [1:0]  RspValid;
  logic [47:0] RspProduct;
  logic [15:0] GrantCnt0, GrantCnt1;

  int errors = 0;
  int checks = 0;

  mul_share_arbiter #(.W(24), .MUL_LAT(LAT)) dut (
    .Clk(Clk), .RstN(RstN), .Flush(Flush),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqA1(ReqA1), .ReqB1(ReqB1),
    .MulValid(MulValid), .MulA(MulA), .MulB(MulB), .MulProduct(MulProduct),
    .RspValid(RspValid), .RspProduct(RspProduct),
    .GrantCnt0(GrantCnt0), .GrantCnt1(GrantCnt1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Multiplier model: product of the issued operands appears LAT cycles later.
  logic [47:0] mulPipe [LAT];
  always @(posedge Clk) begin
    for (int i = LAT - 1; i > 0; i--) mulPipe[i] <= mulPipe[i-1];
    mulPipe[0] <= MulValid ? (48'(MulA) * 48'(MulB)) : 48'hBAD0_0000_0BAD;
  end
  assign MulProduct = mulPipe[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          id;
    logic [47:0] prod;
  } rsp_t;

  rsp_t        pend[$];
  bit          turn = 1'b0;
  bit          expMv = 1'b0;
  logic [23:0] expA = 24'h0, expB = 24'h0;
  int          cnt0 = 0, cnt1 = 0;
  int          cyc = 0;

  function automatic logic [15:0] satCnt(input int c);
    return (c > 65535) ? 16'hFFFF : 16'(c);
  endfunction

  // Compare process: derive every expected output from the model, then advance it.
  always @(negedge Clk) begin : cmp
    logic [1:0]  eg;
    logic [1:0]  er;
    logic [47:0] ep;
    bit          gid;
    if (!RstN) begin
      pend.delete();
      turn = 1'b0; expMv = 1'b0; expA = 24'h0; expB = 24'h0;
      cnt0 = 0; cnt1 = 0;
    end
    eg = 2'b00;
    if (!Flush) eg = (ReqValid == 2'b11) ? (turn ? 2'b10 : 2'b01) : ReqValid;
    er = 2'b00;
    ep = 48'h0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (!Flush) begin
        er = pend[0].id ? 2'b10 : 2'b01;
        ep = pend[0].prod;
      end
      void'(pend.pop_front());
    end
    chk("m_ready",    64'(ReqReady), 64'(eg));
    chk("m_mulvalid", 64'(MulValid), 64'(expMv));
    chk("m_mula",     64'(MulA),     64'(expA));
    chk("m_mulb",     64'(MulB),     64'(expB));
    chk("m_rspvalid", 64'(RspValid), 64'(er));
    if (er != 2'b00) chk("m_rspprod", 64'(RspProduct), 64'(ep));
    chk("m_cnt0", 64'(GrantCnt0), CNT_EN ? 64'(satCnt(cnt0)) : 64'h0);
    chk("m_cnt1", 64'(GrantCnt1), CNT_EN ? 64'(satCnt(cnt1)) : 64'h0);
    if (RstN) begin
      if (Flush) begin
        pend.delete();
        turn  = 1'b0;
        expMv = 1'b0;
      end else if (eg != 2'b00) begin
        gid = eg[1];
        pend.push_back('{due: cyc + 1 + LAT, id: gid,
                         prod: gid ? (48'(ReqA1) * 48'(ReqB1)) : (48'(ReqA0) * 48'(ReqB0))});
        expMv = 1'b1;
        expA  = gid ? ReqA1 : ReqA0;
        expB  = gid ? ReqB1 : ReqB0;
        turn  = ~gid;
        if (gid) cnt1++; else cnt0++;
      end else begin
        expMv = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic doCycle(input logic [1:0] rv, input logic fl, input logic rn);
    @(posedge Clk);
    #1;
    RstN     = rn;
    ReqValid = rv;
    Flush    = fl;
    ReqA0    = 24'($urandom);
    ReqB0    = 24'($urandom);
    ReqA1    = 24'($urandom);
    ReqB1    = 24'($urandom);
    @(negedge Clk);
  endtask

  task automatic doReset();
    doCycle(2'b00, 1'b0, 1'b0);
    doCycle(2'b11, 1'b0, 1'b0);
    chk("rst_ready",    64'(ReqReady),  64'h1);
    chk("rst_mulvalid", 64'(MulValid),  64'h0);
    chk("rst_rspvalid", 64'(RspValid),  64'h0);
    chk("rst_mula",     64'(MulA),      64'h0);
    chk("rst_mulb",     64'(MulB),      64'h0);
    chk("rst_cnt0",     64'(GrantCnt0), 64'h0);
    doCycle(2'b00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [1:0] ex;
    RstN = 1'b0; Flush = 1'b0; ReqValid = 2'b00;
    ReqA0 = 24'h0; ReqB0 = 24'h0; ReqA1 = 24'h0; ReqB1 = 24'h0;

    // Single request from requester 0
    doReset();
    @(posedge Clk);
    #1;
    ReqValid = 2'b01; Flush = 1'b0;
    ReqA0 = 24'h800000; ReqB0 = 24'h800000;
    ReqA1 = 24'($urandom); ReqB1 = 24'($urandom);
    @(negedge Clk);
    chk("single_ready", 64'(ReqReady), 64'h1);
    doCycle(2'b00, 1'b0, 1'b1);
    chk("single_mulvalid", 64'(MulValid), 64'h1);
    chk("single_mula", 64'(MulA), 64'h800000);
    doCycle(2'b00, 1'b0, 1'b1);
    doCycle(2'b00, 1'b0, 1'b1);
    chk("single_early", 64'(RspValid), 64'h0);
    doCycle(2'b00, 1'b0, 1'b1);
    chk("single_rspvalid", 64'(RspValid), 64'h1);
    chk("single_rspprod", 64'(RspProduct), 64'h4000_0000_0000);

    // Contention from reset: alternate grants, responses in issue order
    doReset();
    for (int k = 0; k < 4; k++) begin
      doCycle(2'b11, 1'b0, 1'b1);
      ex = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("cont_grant", 64'(ReqReady), 64'(ex));
    end
    for (int k = 4; k < 8; k++) begin
      doCycle(2'b00, 1'b0, 1'b1);
      ex = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("cont_rsp", 64'(RspValid), 64'(ex));
    end

    // Flush discards in-flight work
    doReset();
    doCycle(2'b01, 1'b0, 1'b1);
    doCycle(2'b01, 1'b0, 1'b1);
    doCycle(2'b01, 1'b1, 1'b1);
    chk("flush_ready", 64'(ReqReady), 64'h0);
    chk("flush_rsp", 64'(RspValid), 64'h0);
    for (int k = 3; k <= 8; k++) begin
      doCycle(2'b00, 1'b0, 1'b1);
      chk("flush_rsp", 64'(RspValid), 64'h0);
    end
    doCycle(2'b10, 1'b1, 1'b1);
    chk("flush_pend_ready", 64'(ReqReady), 64'h0);
    doCycle(2'b10, 1'b0, 1'b1);
    chk("flush_after_ready", 64'(ReqReady), 64'h2);

    // Reset in mid-flight
    doReset();
    doCycle(2'b01, 1'b0, 1'b1);
    doCycle(2'b00, 1'b0, 1'b1);
    chk("midrst_mulvalid1", 64'(MulValid), 64'h1);
    doCycle(2'b00, 1'b0, 1'b0);
    chk("midrst_mula", 64'(MulA), 64'h0);
    chk("midrst_mulvalid", 64'(MulValid), 64'h0);
    chk("midrst_rsp", 64'(RspValid), 64'h0);
    doCycle(2'b00, 1'b0, 1'b1);
    doCycle(2'b00, 1'b0, 1'b1);
    chk("midrst_norsp", 64'(RspValid), 64'h0);

    // Randomized traffic against the model
    doReset();
    for (int k = 0; k < 1500; k++) begin
      doCycle(2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 99) != 0));
    end

    // Counter saturation
    doReset();
    for (int k = 0; k < 70000; k++) doCycle(2'b01, 1'b0, 1'b1);
    doCycle(2'b00, 1'b0, 1'b1);
    chk("cnt0_final", 64'(GrantCnt0), CNT_EN ? 64'hFFFF : 64'h0);
    chk("cnt1_final", 64'(GrantCnt1), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
